// File: rtl/lcd_pkg.sv
// lcd_pkg: opcodes, ROM word width and FSM state encoding shared by the LCD init sequencer.
package lcd_pkg;
  localparam int ROM_W = 10;
  localparam logic [1:0] OP_CMD   = 2'b00;
  localparam logic [1:0] OP_DATA  = 2'b01;
  localparam logic [1:0] OP_DELAY = 2'b10;
  localparam logic [1:0] OP_END   = 2'b11;
  typedef enum logic [3:0] {
    S_IDLE, S_RST_LO, S_RST_HI, S_FETCH, S_DECODE,
    S_SEND, S_DRAIN, S_DELAY, S_DONE, S_ERR
  } state_t;
endpackage

// File: rtl/lcd_ms_timer.sv
// lcd_ms_timer: loadable down-counter that parks at zero and flags it.
module lcd_ms_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else if (load_i) cnt_q <= val_i;
    else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  end
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/lcd_init_sequencer.sv
// lcd_init_sequencer: pulses the panel reset, then plays an init-script ROM out to the SPI byte engine.
module lcd_init_sequencer
  import lcd_pkg::*;
#(
  parameter int ROM_AW      = 6,
  parameter int MS_CYC      = 3375,
  parameter int RST_LOW_MS  = 10,
  parameter int RST_WAIT_MS = 120
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic [ROM_AW-1:0] rom_addr_o,
  input  logic [ROM_W-1:0]  rom_data_i,
  output logic              tx_valid_o,
  output logic [7:0]        tx_data_o,
  output logic              tx_dc_o,
  input  logic              tx_ready_i,
  input  logic              tx_busy_i,
  output logic              lcd_rst_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);
  localparam int TW = $clog2(255 * MS_CYC + 1);
  // Timer is loaded with N-1 so a state lasts exactly N cycles, exiting when it reads 0.
  localparam logic [TW-1:0] LO_V = TW'(RST_LOW_MS * MS_CYC - 1);
  localparam logic [TW-1:0] HI_V = TW'(RST_WAIT_MS * MS_CYC - 1);
  state_t      state_q;
  logic [1:0]  op_q;
  logic [7:0]  arg_q;
  logic        start_ok, last, tmr_load, tmr_zero;
  logic [TW-1:0] dly, tmr_val;
  always_comb begin
    start_ok = start_i & ~busy_o;
    last     = rom_addr_o == '1;
    dly      = TW'(arg_q) * TW'(MS_CYC);
    tmr_val  = state_q == S_RST_LO ? HI_V :
               state_q == S_DRAIN  ? (dly == '0 ? '0 : dly - 1'b1) : LO_V;
    tmr_load = start_ok | (state_q == S_RST_LO & tmr_zero) |
               (state_q == S_DRAIN & ~tx_busy_i & op_q == OP_DELAY);
  end
  lcd_ms_timer #(.W(TW)) u_tmr (
    .clk(clk), .rst(rst), .load_i(tmr_load), .val_i(tmr_val), .zero_o(tmr_zero)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rom_addr_o <= '0;
      tx_valid_o <= 1'b0;
      tx_data_o  <= '0;
      tx_dc_o    <= 1'b0;
      lcd_rst_o  <= 1'b1;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      op_q       <= OP_CMD;
      arg_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERR: if (start_ok) begin
          state_q   <= S_RST_LO;
          lcd_rst_o <= 1'b0;
          busy_o    <= 1'b1;
          done_o    <= 1'b0;
          err_o     <= 1'b0;
        end
        S_RST_LO: if (tmr_zero) begin
          state_q   <= S_RST_HI;
          lcd_rst_o <= 1'b1;
        end
        S_RST_HI: if (tmr_zero) begin
          state_q    <= S_FETCH;
          rom_addr_o <= '0;
        end
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          op_q       <= rom_data_i[9:8];
          arg_q      <= rom_data_i[7:0];
          tx_valid_o <= ~rom_data_i[9];
          tx_data_o  <= rom_data_i[9] ? tx_data_o : rom_data_i[7:0];
          tx_dc_o    <= rom_data_i[9] ? tx_dc_o : rom_data_i[8];
          state_q    <= rom_data_i[9] ? S_DRAIN : S_SEND;
        end
        S_DRAIN: if (!tx_busy_i) begin
          state_q <= op_q == OP_END ? S_DONE : S_DELAY;
          done_o  <= op_q == OP_END;
          busy_o  <= op_q != OP_END;
        end
        // SEND and DELAY share the advance step; the ROM address saturates at its last entry.
        S_SEND, S_DELAY: if (state_q == S_SEND ? tx_ready_i : tmr_zero) begin
          tx_valid_o <= 1'b0;
          state_q    <= last ? S_ERR : S_FETCH;
          rom_addr_o <= last ? rom_addr_o : rom_addr_o + 1'b1;
          err_o      <= last;
          busy_o     <= ~last;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_init_sequencer.sv
// tb_lcd_init_sequencer: directed scripts with a byte scoreboard and cycle-count checks.
module tb_lcd_init_sequencer;
  localparam int AW = 4;
  logic clk = 0, rst = 1, start = 0, tx_ready = 1;
  logic [AW-1:0] rom_addr;
  logic [9:0] rom_data = '0;
  logic tx_valid, tx_dc, tx_busy, lcd_rst, busy, done, err;
  logic [7:0] tx_data;
  logic [9:0] rom [16];
  logic [8:0] exp_q [$];
  int vecs = 0, errs = 0, hs = 0, bcnt = 0;

  always #5 clk = ~clk;

  lcd_init_sequencer #(.ROM_AW(AW), .MS_CYC(4), .RST_LOW_MS(10), .RST_WAIT_MS(120)) dut (
    .clk(clk), .rst(rst), .start_i(start), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
    .tx_valid_o(tx_valid), .tx_data_o(tx_data), .tx_dc_o(tx_dc), .tx_ready_i(tx_ready),
    .tx_busy_i(tx_busy), .lcd_rst_o(lcd_rst), .busy_o(busy), .done_o(done), .err_o(err)
  );

  always @(posedge clk) rom_data <= rom[rom_addr];
  always @(posedge clk)
    if (rst) bcnt <= 0;
    else if (tx_valid && tx_ready) bcnt <= 8;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  assign tx_busy = bcnt != 0;

  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  always @(negedge clk)
    if (!rst && tx_valid && tx_ready) begin
      hs++;
      if (exp_q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL extra byte: got dc=%0d data=0x%02h with nothing expected", tx_dc, tx_data);
      end else chk("byte {dc,data}", int'({tx_dc, tx_data}), int'(exp_q.pop_front()));
    end

  function automatic logic sig(input int s);
    return s == 0 ? tx_valid : s == 1 ? tx_busy : s == 2 ? lcd_rst : s == 3 ? done : err;
  endfunction

  // Call at a negedge; counts negedges until the selected signal equals v.
  task automatic wait_sig(input string nm, input int s, input logic v, output int n);
    n = 0;
    while (sig(s) !== v && n < 3000) begin
      n++;
      @(negedge clk);
    end
    if (sig(s) !== v) begin
      vecs++;
      errs++;
      $display("FAIL %s: timeout after %0d cycles", nm, n);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    @(negedge clk);
  endtask

  task automatic load_a();
    for (int i = 0; i < 16; i++) rom[i] = 10'h300;
    rom[0] = 10'h011; rom[1] = 10'h205; rom[2] = 10'h03A; rom[3] = 10'h155;
    exp_q.push_back(9'h011); exp_q.push_back(9'h03A); exp_q.push_back(9'h155);
  endtask

  task automatic run_full(input string tag);
    int n;
    pulse_start();
    wait_sig({tag, " lcd_rst rise"}, 2, 1'b1, n);
    chk({tag, " lcd_rst low cycles"}, n, 40);
    wait_sig({tag, " first tx_valid"}, 0, 1'b1, n);
    chk({tag, " lcd_rst high to first tx_valid"}, n, 482);
  endtask

  initial begin
    int n, h0;
    logic [8:0] cap;
    int bad;
    load_a();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset lcd_rst", lcd_rst, 1);
    chk("reset tx_valid", tx_valid, 0);
    chk("reset tx_data/dc", {tx_dc, tx_data}, 0);
    chk("reset rom_addr", rom_addr, 0);
    chk("reset busy/done/err", {busy, done, err}, 0);
    // Script A: full timing, byte order, DELAY 5 gap
    h0 = hs;
    run_full("A");
    chk("A busy during send", busy, 1);
    wait_sig("A busy rise", 1, 1'b1, n);
    wait_sig("A busy fall", 1, 1'b0, n);
    wait_sig("A second tx_valid", 0, 1'b1, n);
    chk("A delay5 gap", n, 23);
    wait_sig("A done", 3, 1'b1, n);
    chk("A done flags {busy,done,err}", {busy, done, err}, 3'b010);
    chk("A bytes left", exp_q.size(), 0);
    chk("A handshakes", hs - h0, 3);
    // Script B: ready held low 20 cycles, DELAY 0
    for (int i = 0; i < 16; i++) rom[i] = 10'h300;
    rom[0] = 10'h0A1; rom[1] = 10'h200; rom[2] = 10'h1B2;
    exp_q.push_back(9'h0A1); exp_q.push_back(9'h1B2);
    tx_ready = 0;
    h0 = hs;
    pulse_start();
    chk("B start clears done", done, 0);
    wait_sig("B first tx_valid", 0, 1'b1, n);
    cap = {tx_dc, tx_data};
    chk("B held byte", cap, 9'h0A1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (!tx_valid || {tx_dc, tx_data} !== cap) bad++;
      @(negedge clk);
    end
    chk("B stable while not ready", bad, 0);
    chk("B no handshake while not ready", hs - h0, 0);
    @(posedge clk); #1 tx_ready = 1;
    @(negedge clk);
    wait_sig("B busy rise", 1, 1'b1, n);
    wait_sig("B busy fall", 1, 1'b0, n);
    wait_sig("B second tx_valid", 0, 1'b1, n);
    chk("B delay0 gap", n, 4);
    wait_sig("B done", 3, 1'b1, n);
    chk("B handshakes", hs - h0, 2);
    chk("B bytes left", exp_q.size(), 0);
    // rst during DELAY, then rerun
    load_a();
    pulse_start();
    wait_sig("R first tx_valid", 0, 1'b1, n);
    wait_sig("R busy rise", 1, 1'b1, n);
    wait_sig("R busy fall", 1, 1'b0, n);
    repeat (5) @(negedge clk);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("R after rst lcd_rst", lcd_rst, 1);
    chk("R after rst tx_valid", tx_valid, 0);
    chk("R after rst busy", busy, 0);
    chk("R after rst rom_addr", rom_addr, 0);
    exp_q.delete();
    load_a();
    h0 = hs;
    run_full("R");
    wait_sig("R done", 3, 1'b1, n);
    chk("R handshakes", hs - h0, 3);
    chk("R bytes left", exp_q.size(), 0);
    // No END: all entries sent, then ERR; start while busy ignored
    for (int i = 0; i < 16; i++) begin
      rom[i] = 10'h000;
      exp_q.push_back(9'h000);
    end
    h0 = hs;
    pulse_start();
    wait_sig("E first tx_valid", 0, 1'b1, n);
    pulse_start();
    chk("E busy after ignored start", busy, 1);
    chk("E lcd_rst after ignored start", lcd_rst, 1);
    wait_sig("E err", 4, 1'b1, n);
    chk("E flags {busy,done,err}", {busy, done, err}, 3'b001);
    chk("E rom_addr at max", rom_addr, 15);
    repeat (10) @(negedge clk);
    chk("E rom_addr held", rom_addr, 15);
    chk("E handshakes", hs - h0, 16);
    chk("E bytes left", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
